// File: rtl/led_status_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_status_bank                                               |
// | Purpose  : N_CH-channel LED indicator controller. Each channel is off,   |
// |            steady, blinking (shared phase) or showing a retriggerable    |
// |            one-shot hold. All channels share a millisecond timebase.     |
// | Ports    : clk, rst        - clock, synchronous active-high reset         |
// |            mode[2*N_CH]    - per-channel mode, 00 off/01 on/10 blink/    |
// |                              11 hold                                     |
// |            trig[N_CH]      - hold trigger, rising-edge sensitive         |
// |            clr[N_CH]       - hold abort, level                           |
// |            lamp_test       - force every LED on                          |
// |            bright[8]       - PWM dim level (LED_BANK_PWM_DIM_EN only)    |
// |            led[N_CH]       - registered LED drive, 1 = lit               |
// |            hold_busy[N_CH] - registered, 1 while the hold timer runs     |
// | Options  : define LED_BANK_PWM_DIM_EN to add PWM dimming via `bright`.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module led_status_bank #(
  parameter int N_CH          = 4,
  parameter int CLK_FREQ      = 50_000_000,
  parameter int BLINK_HALF_MS = 250,
  parameter int HOLD_MS       = 3000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   trig,
  input  logic [N_CH-1:0]   clr,
  input  logic              lamp_test,
`ifdef LED_BANK_PWM_DIM_EN
  input  logic [7:0]        bright,
`endif
  output logic [N_CH-1:0]   led,
  output logic [N_CH-1:0]   hold_busy
);

  localparam int DIV   = CLK_FREQ / 1000;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int MS_W  = (BLINK_HALF_MS > 1) ? $clog2(BLINK_HALF_MS) : 1;
  localparam int TMR_W = $clog2(HOLD_MS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------------------------------------------------------------
  // Millisecond timebase. With DIV=1 the count is stuck at 0 and tick is
  // high every cycle.
  // ---------------------------------------------------------------------
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick;

  always_comb begin
    tick  = (pre_q == PRE_W'(DIV - 1));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
  end

  // ---------------------------------------------------------------------
  // Shared blink phase; free-running, never touched by mode changes.
  // ---------------------------------------------------------------------
  logic [MS_W-1:0] ms_q, ms_d;
  logic            phase_q, phase_d;

  always_comb begin
    ms_d    = ms_q;
    phase_d = phase_q;
    if (tick) begin
      if (ms_q == MS_W'(BLINK_HALF_MS - 1)) begin
        ms_d    = '0;
        phase_d = ~phase_q;
      end else begin
        ms_d = ms_q + MS_W'(1);
      end
    end
  end

  // Previous trig sample for rising-edge detection.
  logic [N_CH-1:0] trig_prev_q, trig_prev_d;
  assign trig_prev_d = trig;

`ifdef LED_BANK_PWM_DIM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on;
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_on    = (pwm_cnt_q < bright);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= '0;
      ms_q        <= '0;
      phase_q     <= 1'b0;
      trig_prev_q <= '0;
    end else begin
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      phase_q     <= phase_d;
      trig_prev_q <= trig_prev_d;
    end
  end

`ifdef LED_BANK_PWM_DIM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Per-channel hold FSM and lit value.
  // ---------------------------------------------------------------------
  logic [N_CH-1:0] lit_vec;
  logic [N_CH-1:0] run_vec;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       ch_mode;
    logic             rise;
    logic             hold_sel;
    logic [0:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             run;
    logic             lit;

    assign ch_mode  = mode[2*i +: 2];
    assign rise     = trig[i] & ~trig_prev_q[i];
    assign hold_sel = (ch_mode == 2'b11);

    // State register
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_IDLE;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        tmr_q   <= tmr_d;
      end
    end

    // Next state: abort beats retrigger, retrigger beats countdown.
    always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      if (clr[i] || !hold_sel) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else if (rise) begin
        state_d = ST_RUN;
        tmr_d   = TMR_W'(HOLD_MS);
      end else if ((state_q == ST_RUN) && tick) begin
        // <= 1 also covers a zero timer so it can never wrap.
        if (tmr_q <= TMR_W'(1)) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
    end

    // Output decode
    always_comb begin
      run = (state_q == ST_RUN);
      case (ch_mode)
        2'b00:   lit = 1'b0;
        2'b01:   lit = 1'b1;
        2'b10:   lit = phase_q;
        default: lit = run;
      endcase
`ifdef LED_BANK_PWM_DIM_EN
      lit = lit & pwm_on;
`endif
    end

    assign lit_vec[i] = lit;
    assign run_vec[i] = run;
  end

  // ---------------------------------------------------------------------
  // Output registers. Lamp test overrides after dimming so it is always
  // full brightness.
  // ---------------------------------------------------------------------
  logic [N_CH-1:0] led_q, led_d;
  logic [N_CH-1:0] hold_busy_q, hold_busy_d;

  always_comb begin
    led_d       = lamp_test ? {N_CH{1'b1}} : lit_vec;
    hold_busy_d = run_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q       <= '0;
      hold_busy_q <= '0;
    end else begin
      led_q       <= led_d;
      hold_busy_q <= hold_busy_d;
    end
  end

  assign led       = led_q;
  assign hold_busy = hold_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_led_status_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_status_bank                                            |
// | Purpose  : Self-checking bench for led_status_bank (N_CH=4, DIV=1,       |
// |            BLINK_HALF_MS=2, HOLD_MS=5). A cycle-level reference model   |
// |            tracks remaining hold time and elapsed cycles; directed       |
// |            scenarios pin the model with literal expectations, then       |
// |            random stimulus exercises everything together.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_led_status_bank;

  localparam int N_CH = 4;
  localparam int CLK_FREQ = 1000;
  localparam int BH = 2;
  localparam int HM = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mode;
  logic [3:0] trig;
  logic [3:0] clr;
  logic       lamp_test;
  logic [3:0] led;
  logic [3:0] hold_busy;
`ifdef LED_BANK_PWM_DIM_EN
  logic [7:0] bright;
`endif

  led_status_bank #(
    .N_CH(N_CH), .CLK_FREQ(CLK_FREQ), .BLINK_HALF_MS(BH), .HOLD_MS(HM)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .trig(trig), .clr(clr),
    .lamp_test(lamp_test),
`ifdef LED_BANK_PWM_DIM_EN
    .bright(bright),
`endif
    .led(led), .hold_busy(hold_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ------------------------- reference model ---------------------------
  // n = clock edges since reset; blink phase is (n / BH) mod 2 and the
  // PWM count is n mod 256. rem[c] = hold cycles still to run.
  int         n;
  int         rem [N_CH];
  logic [3:0] prev_trig;
  logic [3:0] exp_led, exp_busy;
  bit         model_ok = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      n = 0;
      for (int c = 0; c < N_CH; c++) rem[c] = 0;
      prev_trig = 4'b0;
      exp_led   = 4'b0;
      exp_busy  = 4'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      for (int c = 0; c < N_CH; c++) begin
        int  m;
        bit  lit;
        bit  busy;
        m    = int'(mode[2*c +: 2]);
        busy = (rem[c] > 0);
        case (m)
          0:       lit = 1'b0;
          1:       lit = 1'b1;
          2:       lit = ((n / BH) % 2) == 1;
          default: lit = busy;
        endcase
`ifdef LED_BANK_PWM_DIM_EN
        lit = lit && ((n % 256) < int'(bright));
`endif
        exp_led[c]  = lamp_test | lit;
        exp_busy[c] = busy;
        if (clr[c] || m != 3)              rem[c] = 0;
        else if (trig[c] && !prev_trig[c]) rem[c] = HM;
        else if (rem[c] > 0)               rem[c] = rem[c] - 1;
      end
      prev_trig = trig;
      n = n + 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if (led !== exp_led) begin
        failures++;
        $display("FAIL model_led t=%0t actual=%b required=%b", $time, led, exp_led);
      end
      checks++;
      if (hold_busy !== exp_busy) begin
        failures++;
        $display("FAIL model_busy t=%0t actual=%b required=%b", $time, hold_busy, exp_busy);
      end
    end
  end

  // --------------------------- helpers ---------------------------------
  int cnt_busy;
  int cnt_led;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Advance one cycle, tallying channel 2's outputs at the sample point.
  task automatic step();
    @(negedge clk);
    if (hold_busy[2] === 1'b1) cnt_busy++;
    if (led[2] === 1'b1) cnt_led++;
  endtask

  task automatic clear_cnt();
    cnt_busy = 0;
    cnt_led  = 0;
  endtask

  // --------------------------- stimulus --------------------------------
  initial begin
    int on_cnt;
    rst = 1'b1; mode = 8'h55; trig = 4'b0; clr = 4'b0; lamp_test = 1'b0;
`ifdef LED_BANK_PWM_DIM_EN
    bright = 8'd64;
`endif
    repeat (3) begin
      step();
      chk("rst_led", int'(led), 0);
      chk("rst_busy", int'(hold_busy), 0);
    end

`ifdef LED_BANK_PWM_DIM_EN
    rst = 1'b0;
    on_cnt = 0;
    repeat (256) begin step(); if (led[0]) on_cnt++; end
    chk("pwm_bright64", on_cnt, 64);
    bright = 8'd0; step();
    on_cnt = 0;
    repeat (256) begin step(); if (led[0]) on_cnt++; end
    chk("pwm_bright0", on_cnt, 0);
    lamp_test = 1'b1; step();
    on_cnt = 0;
    repeat (256) begin step(); if (led[0]) on_cnt++; end
    chk("pwm_lamp", on_cnt, 256);
    lamp_test = 1'b0;
    bright = 8'd200;
`else
    rst = 1'b0;
    step();
    chk("post_rst_led", int'(led), 15);

    // Single-cycle trigger on channel 2.
    mode = 8'h30; step();
    clear_cnt();
    trig = 4'b0100; step(); trig = 4'b0;
    repeat (10) step();
    chk("hold_pulse_busy", cnt_busy, 5);
    chk("hold_pulse_led", cnt_led, 5);

    // Trigger held high for 10 cycles still gives one hold.
    clear_cnt();
    trig = 4'b0100; repeat (10) step(); trig = 4'b0;
    repeat (4) step();
    chk("hold_level_busy", cnt_busy, 5);

    // Retrigger 3 cycles into the hold.
    clear_cnt();
    trig = 4'b0100; step(); trig = 4'b0; step(); step();
    trig = 4'b0100; step(); trig = 4'b0;
    repeat (10) step();
    chk("retrig_busy", cnt_busy, 8);
    chk("retrig_led", cnt_led, 8);

    // Trigger and clear together: nothing starts.
    clear_cnt();
    trig = 4'b0100; clr = 4'b0100; step(); trig = 4'b0; clr = 4'b0;
    repeat (8) step();
    chk("trig_clr_busy", cnt_busy, 0);

    // Clear mid-hold.
    trig = 4'b0100; step(); trig = 4'b0; step(); step();
    chk("clr_pre", int'(led[2]), 1);
    clr = 4'b0100; step();
    chk("clr_same", int'(led[2]), 1);
    step();
    chk("clr_drop", int'(led[2]), 0);
    clr = 4'b0;

    // Mode 11 -> 01 mid-hold.
    trig = 4'b0100; step(); trig = 4'b0; step(); step();
    mode = 8'h10; step(); step();
    chk("mode_sw_busy", int'(hold_busy[2]), 0);
    chk("mode_sw_led", int'(led[2]), 1);

    // Lamp test with everything off.
    mode = 8'h00; lamp_test = 1'b1; step();
    chk("lamp_all", int'(led), 15);
    lamp_test = 1'b0; step();
    chk("lamp_off", int'(led), 0);

    // Hold keeps counting underneath lamp test.
    mode = 8'h30; step();
    clear_cnt();
    trig = 4'b0100; step(); trig = 4'b0;
    lamp_test = 1'b1; step(); step(); lamp_test = 1'b0;
    repeat (8) step();
    chk("lamp_hold_busy", cnt_busy, 5);
    chk("lamp_hold_led", cnt_led, 5);
    chk("lamp_hold_end", int'(led[2]), 0);

    // Blink on ch0 from reset; ch1 joins mid-period on the same phase.
    rst = 1'b1; mode = 8'h02; step(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("blink_ch0", int'(led[0]), (i / 2) % 2);
      if (i >= 3) chk("blink_ch1", int'(led[1]), (i / 2) % 2);
      if (i == 2) mode = 8'h0A;
    end
`endif

    // Randomized phase, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) mode = 8'($urandom);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) trig[b] = ~trig[b];
      clr = ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'b0;
      lamp_test = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 999) == 0);
`ifdef LED_BANK_PWM_DIM_EN
      if ($urandom_range(0, 99) == 0) bright = 8'($urandom);
`endif
      step();
    end
    rst = 1'b0; lamp_test = 1'b0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
